// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU/load requesters and the register file port.
// The slave side is the arbiter; the master side drives the requests.
interface regfile_write_arbiter_if;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        regwrite;
    logic [4:0]  wr_addr;
    logic [31:0] W_Data;
    logic        grant_src;

    modport slave (
        input  stall,
        input  alu_valid,
        input  alu_rd,
        input  alu_data,
        output alu_ready,
        input  ld_valid,
        input  ld_rd,
        input  ld_data,
        output ld_ready,
        output regwrite,
        output wr_addr,
        output W_Data,
        output grant_src
    );

    modport master (
        output stall,
        output alu_valid,
        output alu_rd,
        output alu_data,
        input  alu_ready,
        output ld_valid,
        output ld_rd,
        output ld_data,
        input  ld_ready,
        input  regwrite,
        input  wr_addr,
        input  W_Data,
        input  grant_src
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-port register-file writeback arbiter: loads win by default, the ALU
// wins once it has been refused STARVE_MAX cycles in a row.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input logic               clk,
    input logic               reset,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_q, starve_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_q, src_d;

    logic starve_full;
    logic alu_go;
    logic ld_go;

    assign starve_full = (starve_q == STARVE_LIM);

    // Grants are purely combinational; reset and stall gate both ports.
    always_comb begin
        alu_go = 1'b0;
        ld_go  = 1'b0;
        if (!reset && !bus.stall) begin
            ld_go  = bus.ld_valid && !(bus.alu_valid && starve_full);
            alu_go = bus.alu_valid && !ld_go;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.stall) begin
            if (!bus.alu_valid || alu_go) begin
                starve_d = 4'd0;
            end else if (!starve_full) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Writes to x0 still update address/data but never assert the enable.
    always_comb begin
        regwrite_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wdata_d    = wdata_q;
        src_d      = src_q;
        unique case (1'b1)
            ld_go: begin
                regwrite_d = (bus.ld_rd != 5'd0);
                wr_addr_d  = bus.ld_rd;
                wdata_d    = bus.ld_data;
                src_d      = 1'b1;
            end
            alu_go: begin
                regwrite_d = (bus.alu_rd != 5'd0);
                wr_addr_d  = bus.alu_rd;
                wdata_d    = bus.alu_data;
                src_d      = 1'b0;
            end
            default: begin
                regwrite_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q   <= 4'd0;
            regwrite_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wdata_q    <= 32'd0;
            src_q      <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            wr_addr_q  <= wr_addr_d;
            wdata_q    <= wdata_d;
            src_q      <= src_d;
        end
    end

    assign bus.alu_ready = alu_go;
    assign bus.ld_ready  = ld_go;
    assign bus.regwrite  = regwrite_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.W_Data    = wdata_q;
    assign bus.grant_src = src_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the writeback arbiter against a
// cycle-level reference model of the grant and starvation rules.
module tb_regfile_write_arbiter;
    localparam int STARVE_MAX = 3;

    logic clk;
    logic reset;
    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          waited = 0;
    logic        m_alu;
    logic        m_ld;
    logic        e_we   = 1'b0;
    logic [4:0]  e_addr = 5'd0;
    logic [31:0] e_data = 32'd0;
    logic        e_src  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".regwrite"}, 32'(bus.regwrite), 32'(e_we));
        check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(e_addr));
        check({tag, ".W_Data"}, bus.W_Data, e_data);
        check({tag, ".grant_src"}, 32'(bus.grant_src), 32'(e_src));
    endtask

    task automatic drive(input logic st, input logic av, input logic [4:0] ar,
                         input logic [31:0] ad, input logic lv,
                         input logic [4:0] lr, input logic [31:0] ldd);
        bus.stall     = st;
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lr;
        bus.ld_data   = ldd;
    endtask

    // One clock cycle: drive, check readies, clock, update model, check outputs.
    task automatic step(input string tag, input logic st, input logic av,
                        input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr,
                        input logic [31:0] ldd);
        drive(st, av, ar, ad, lv, lr, ldd);
        #1;
        m_ld  = !st && lv && !(av && waited >= STARVE_MAX);
        m_alu = !st && av && !m_ld;
        check({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(m_alu));
        check({tag, ".ld_ready"}, 32'(bus.ld_ready), 32'(m_ld));
        @(posedge clk);
        #1;
        if (m_ld) begin
            e_we = (lr != 5'd0); e_addr = lr; e_data = ldd; e_src = 1'b1;
        end else if (m_alu) begin
            e_we = (ar != 5'd0); e_addr = ar; e_data = ad; e_src = 1'b0;
        end else begin
            e_we = 1'b0;
        end
        if (!st) begin
            if (av && !m_alu)
                waited = (waited < STARVE_MAX) ? waited + 1 : waited;
            else
                waited = 0;
        end
        check_outs(tag);
    endtask

    task automatic model_reset();
        waited = 0;
        e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_src = 1'b0;
    endtask

    logic        a_pend, l_pend;
    logic [4:0]  a_rd, l_rd;
    logic [31:0] a_dat, l_dat;
    logic        rst_st;
    logic [3:0]  exp_seq;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        model_reset();
        check_outs("reset");
        check("reset.alu_ready", 32'(bus.alu_ready), 32'd0);
        check("reset.ld_ready", 32'(bus.ld_ready), 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ALU write
        step("alu1", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("alu1.W_Data_k", bus.W_Data, 32'hDEADBEEF);
        step("idle", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("idle.hold_addr", 32'(bus.wr_addr), 32'd5);

        // x0 suppression
        step("x0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        check("x0.regwrite_k", 32'(bus.regwrite), 32'd0);
        check("x0.W_Data_k", bus.W_Data, 32'h1234);

        // Contention: L,L,L,A,L,L,L,A
        exp_seq = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            step("contend", 1'b0, 1'b1, 5'd10, 32'hA0A0, 1'b1, 5'd11, 32'hB0B0);
            check("contend.order", 32'(bus.grant_src), 32'(exp_seq[3 - (i % 4)]));
        end
        step("clr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Stall with starvation count at 2
        step("pre1", 1'b0, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD1);
        step("pre2", 1'b0, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD2);
        step("stall1", 1'b1, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD3);
        check("stall1.regwrite_k", 32'(bus.regwrite), 32'd0);
        step("stall2", 1'b1, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD3);
        step("post1", 1'b0, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD3);
        check("post1.src_k", 32'(bus.grant_src), 32'd1);
        step("post2", 1'b0, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD4);
        check("post2.src_k", 32'(bus.grant_src), 32'd0);
        step("clr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Same-address collision
        step("coll1", 1'b0, 1'b1, 5'd7, 32'hAAAA0007, 1'b1, 5'd7, 32'hBBBB0007);
        check("coll1.W_Data_k", bus.W_Data, 32'hBBBB0007);
        step("coll2", 1'b0, 1'b1, 5'd7, 32'hAAAA0007, 1'b0, 5'd0, 32'd0);
        check("coll2.W_Data_k", bus.W_Data, 32'hAAAA0007);
        check("coll2.addr_k", 32'(bus.wr_addr), 32'd7);
        step("clr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Async reset mid-cycle while regwrite=1 and starvation saturated
        step("r1", 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h91);
        step("r2", 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h92);
        step("r3", 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h93);
        check("r3.regwrite_k", 32'(bus.regwrite), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outs("async");
        check("async.alu_ready", 32'(bus.alu_ready), 32'd0);
        check("async.ld_ready", 32'(bus.ld_ready), 32'd0);
        @(posedge clk);
        #1;
        check_outs("inreset");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postrst.regwrite", 32'(bus.regwrite), 32'd0);
        step("postrst", 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h94);
        check("postrst.src_k", 32'(bus.grant_src), 32'd1);
        step("clr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Randomized traffic; requesters hold payload until accepted
        a_pend = 1'b0; l_pend = 1'b0;
        a_rd = 5'd0; l_rd = 5'd0; a_dat = 32'd0; l_dat = 32'd0;
        for (int i = 0; i < 300; i++) begin
            if (!a_pend && $urandom_range(2, 0) != 0) begin
                a_pend = 1'b1;
                a_rd   = 5'($urandom_range(31, 0));
                a_dat  = $urandom;
            end
            if (!l_pend && $urandom_range(2, 0) != 0) begin
                l_pend = 1'b1;
                l_rd   = 5'($urandom_range(31, 0));
                l_dat  = $urandom;
            end
            rst_st = ($urandom_range(5, 0) == 0);
            step("rand", rst_st, a_pend, a_rd, a_dat, l_pend, l_rd, l_dat);
            if (m_alu) a_pend = 1'b0;
            if (m_ld)  l_pend = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
